seq_101101_gen: RTL

SEQ_101101_GEN -- requirements
Module: seq_101101_gen

---
 rtl/seq_101101_gen.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/seq_101101_gen.sv
// seq_101101_gen: serial frame generator.
// A frame is the sync word 101101 (MSB first), then PAYLOAD_W payload bits
// (MSB first), optionally followed by one even-parity bit, then IDLE_GAP
// idle cycles. The frame ends with a one-cycle done pulse.
// Optional feature macro: SEQ_GEN_PARITY_EN (appends the even-parity bit).
//
// Handshake: data_out/valid are registered. A bit is transferred on every
// rising clk edge where valid=1 and ready=1; while ready=0 both data_out and
// valid hold, so no bit is ever skipped or repeated. start is only looked at
// in IDLE, and payload is captured on that same accepted edge.
//
// state_dbg exposes the FSM state encoding (IDLE=0, SYNC=1, PAYLOAD=2,
// PARITY=3, GAP=4) for checkers and debug.
module seq_101101_gen #(
    parameter int PAYLOAD_W = 8,
    parameter int IDLE_GAP  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [PAYLOAD_W-1:0] payload,
    input  logic                 ready,
    output logic                 data_out,
    output logic                 valid,
    output logic                 busy,
    output logic                 done,
    output logic [2:0]           state_dbg
);

    localparam int         CNT_W    = (PAYLOAD_W > 1) ? $clog2(PAYLOAD_W) : 1;
    localparam logic [5:0] SYNC_PAT = 6'b101101;
    localparam logic [3:0] GAP_LOAD = (IDLE_GAP > 0) ? 4'(IDLE_GAP - 1) : 4'd0;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SYNC    = 3'd1,
        PAYLOAD = 3'd2,
`ifdef SEQ_GEN_PARITY_EN
        PARITY  = 3'd3,
`endif
        GAP     = 3'd4
    } state_t;

    state_t               state;
    logic [PAYLOAD_W-1:0] payload_q;  // frame data latched at start
    logic [2:0]           sync_cnt;   // index of sync bit on data_out, 5..0
    logic [CNT_W-1:0]     bit_cnt;    // index of payload bit on data_out
    logic [3:0]           gap_cnt;    // remaining gap cycles after this one
    logic                 last_xfer;  // final bit of the frame transfers now

    assign state_dbg = state;

    // Detect the edge that transfers the last bit of the frame.
    always_comb begin
        last_xfer = 1'b0;
`ifdef SEQ_GEN_PARITY_EN
        if (ready && state == PARITY)
            last_xfer = 1'b1;
`else
        if (ready && state == PAYLOAD && bit_cnt == '0)
            last_xfer = 1'b1;
`endif
    end

    // Frame FSM with registered outputs; reset overrides start and ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            payload_q <= '0;
            sync_cnt  <= '0;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
            data_out  <= 1'b0;
            valid     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (last_xfer) begin
                // Frame complete: drop valid and pulse done on GAP entry.
                valid    <= 1'b0;
                data_out <= 1'b0;
                done     <= 1'b1;
                if (IDLE_GAP == 0) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end else begin
                    state   <= GAP;
                    gap_cnt <= GAP_LOAD;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            payload_q <= payload;
                            sync_cnt  <= 3'd5;
                            state     <= SYNC;
                            valid     <= 1'b1;
                            busy      <= 1'b1;
                            data_out  <= SYNC_PAT[5];
                        end
                    end
                    SYNC: begin
                        if (ready) begin
                            if (sync_cnt == 3'd0) begin
                                state    <= PAYLOAD;
                                bit_cnt  <= CNT_W'(PAYLOAD_W - 1);
                                data_out <= payload_q[PAYLOAD_W-1];
                            end else begin
                                sync_cnt <= sync_cnt - 3'd1;
                                data_out <= SYNC_PAT[sync_cnt - 3'd1];
                            end
                        end
                    end
                    PAYLOAD: begin
                        if (ready) begin
                            if (bit_cnt != '0) begin
                                bit_cnt  <= bit_cnt - 1'b1;
                                data_out <= payload_q[bit_cnt - 1'b1];
                            end
`ifdef SEQ_GEN_PARITY_EN
                            else begin
                                state    <= PARITY;
                                data_out <= ^payload_q;
                            end
`endif
                        end
                    end
                    GAP: begin
                        if (gap_cnt == 4'd0) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            gap_cnt <= gap_cnt - 4'd1;
                        end
                    end
                    default: begin
                        // PARITY waits here for ready; last_xfer ends it.
                        state <= state;
                    end
                endcase
            end
        end
    end

endmodule
